// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg
// Shared types for the stack sequencer: FSM state encoding, the operation
// being sequenced, and the write-data select encodings that the data-memory
// stage understands.
package stack_seq_pkg;

  // Sequencer states. The CCR states only become reachable when the
  // interrupt path is built.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_CCR = 3'd1,
    PUSH_HI  = 3'd2,
    PUSH_LO  = 3'd3,
    POP_LO   = 3'd4,
    POP_HI   = 3'd5,
    POP_CCR  = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Operation accepted in IDLE; it selects the PC source in DONE.
  typedef enum logic [1:0] {
    CALL = 2'd0,
    RET  = 2'd1,
    INT  = 2'd2,
    RTI  = 2'd3
  } op_e;

  // Write-data select (sel1) encodings.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_PCLO = 2'b01;
  localparam logic [1:0] SEL_PCHI = 2'b10;
  localparam logic [1:0] SEL_CCR  = 2'b11;

endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer
// Turns CALL / RET / INT / RTI into 16-bit push and pop sequences on the
// data-memory stage, captures popped words, and hands the restored PC (and
// flags) back to fetch and the flag register. Fetch/decode stall while a
// sequence runs.
//
// Build option: define STACK_SEQ_INT_EN to build the INT/RTI paths, the
// PUSH_CCR/POP_CCR states and the ccr_load/ccr_out logic. Without it only
// CALL/RET are sequenced, int_req/rti_req are ignored and ccr_* are tied 0.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   call_req, ret_req, int_req, rti_req
//                     requests, sampled only in IDLE (int > call > ret > rti)
//   target            CALL destination PC, latched when CALL is accepted
//   ccr_in            current flags (pushed via the data-memory CCR path)
//   mem_rdata         data-memory read data, captured at the end of each pop
//   MR, MW            memory read / write strobes
//   sel1              write-data select (ALU / PC low / PC high / CCR)
//   sel2              selects the stack-pointer address (MR | MW)
//   stall             freezes fetch/decode
//   pc_load, pc_out   one-cycle PC load pulse and the PC to load
//   ccr_load, ccr_out one-cycle flag load pulse and the restored flags
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic [31:0] target,
  input  logic [2:0]  ccr_in,
  input  logic [15:0] mem_rdata,
  output logic        MR,
  output logic        MW,
  output logic [1:0]  sel1,
  output logic        sel2,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        ccr_load,
  output logic [2:0]  ccr_out
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] target_q, target_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic        req_s;

`ifdef STACK_SEQ_INT_EN
  logic [2:0]  ccr_q, ccr_d;
  logic        unused_s;

  // Any request the sequencer is able to act on.
  assign req_s    = int_req | call_req | ret_req | rti_req;
  // Flags are pushed through the data-memory path, not from this port.
  assign unused_s = ^ccr_in;
`else
  logic        unused_s;

  assign req_s    = call_req | ret_req;
  // Interrupt inputs and the vector have no function in this build.
  assign unused_s = ^{ccr_in, int_req, rti_req, INT_VECTOR};
`endif

  // State and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= CALL;
      target_q <= 32'h0000_0000;
      lo_q     <= 16'h0000;
      hi_q     <= 16'h0000;
`ifdef STACK_SEQ_INT_EN
      ccr_q    <= 3'b000;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      target_q <= target_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
`ifdef STACK_SEQ_INT_EN
      ccr_q    <= ccr_d;
`endif
    end
  end

  // Next-state, request arbitration and pop-data capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    target_d = target_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
`ifdef STACK_SEQ_INT_EN
    ccr_d    = ccr_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef STACK_SEQ_INT_EN
        if (int_req) begin
          state_d = PUSH_CCR;
          op_d    = INT;
        end else
`endif
        if (call_req) begin
          state_d  = PUSH_HI;
          op_d     = CALL;
          target_d = target;
        end else if (ret_req) begin
          state_d = POP_LO;
          op_d    = RET;
`ifdef STACK_SEQ_INT_EN
        end else if (rti_req) begin
          state_d = POP_LO;
          op_d    = RTI;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef STACK_SEQ_INT_EN
      PUSH_CCR: state_d = PUSH_HI;
`endif
      PUSH_HI:  state_d = PUSH_LO;
      PUSH_LO:  state_d = DONE;
      POP_LO: begin
        lo_d    = mem_rdata;
        state_d = POP_HI;
      end
      POP_HI: begin
        hi_d = mem_rdata;
`ifdef STACK_SEQ_INT_EN
        if (op_q == RTI) begin
          state_d = POP_CCR;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
`ifdef STACK_SEQ_INT_EN
      POP_CCR: begin
        // Only the three flag bits of the popped word are meaningful.
        ccr_d   = mem_rdata[2:0];
        state_d = DONE;
      end
`endif
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode; strobes are purely state-driven, stall also sees requests in IDLE.
  always_comb begin
    stall    = 1'b0;
    MR       = 1'b0;
    MW       = 1'b0;
    sel1     = SEL_ALU;
    pc_load  = 1'b0;
    pc_out   = 32'h0000_0000;
    ccr_load = 1'b0;
    ccr_out  = 3'b000;
    case (state_q)
      IDLE:     stall = req_s;
`ifdef STACK_SEQ_INT_EN
      PUSH_CCR: begin
        stall = 1'b1;
        MW    = 1'b1;
        sel1  = SEL_CCR;
      end
      POP_CCR: begin
        stall = 1'b1;
        MR    = 1'b1;
      end
`endif
      PUSH_HI: begin
        stall = 1'b1;
        MW    = 1'b1;
        sel1  = SEL_PCHI;
      end
      PUSH_LO: begin
        stall = 1'b1;
        MW    = 1'b1;
        sel1  = SEL_PCLO;
      end
      POP_LO, POP_HI: begin
        stall = 1'b1;
        MR    = 1'b1;
      end
      DONE: begin
        pc_load = 1'b1;
        case (op_q)
          CALL: pc_out = target_q;
          RET:  pc_out = {hi_q, lo_q};
`ifdef STACK_SEQ_INT_EN
          INT:  pc_out = INT_VECTOR;
          RTI: begin
            pc_out   = {hi_q, lo_q};
            ccr_load = 1'b1;
            ccr_out  = ccr_q;
          end
`endif
          default: pc_out = 32'h0000_0000;
        endcase
      end
      default: stall = 1'b0;
    endcase
    // The stack address is used exactly when a stack access is in flight.
    sel2 = MR | MW;
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer
// Self-checking bench for stack_sequencer: a directed vector table for the
// CALL/RET example, hand-written corner sequences (reset mid-push, priority,
// interrupt path or its absence), then random operation streams checked
// against a word-stack reference model. A small data-memory model answers
// the DUT's strobes (push: write at SP then SP-1, pop: read at SP+1).
module tb_stack_sequencer;

`ifdef STACK_SEQ_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  localparam logic [31:0] VEC     = 32'h0000_0010;
  localparam logic [12:0] CCR_PAD = 13'h1555;

  logic        clk = 1'b0;
  logic        rst, call_req, ret_req, int_req, rti_req;
  logic [31:0] target;
  logic [2:0]  ccr_in;
  logic [15:0] mem_rdata;
  logic        mr, mw, sel2, stall, pc_load, ccr_load;
  logic [1:0]  sel1;
  logic [31:0] pc_out;
  logic [2:0]  ccr_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] cur_pc;
  logic [2:0]  ccr_cur;
  logic [15:0] mem [0:2047];
  logic [10:0] sp;
  logic [15:0] wdata;
  logic [15:0] mstk [$];

  always #5 clk = ~clk;

  stack_sequencer #(.INT_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .int_req(int_req), .rti_req(rti_req), .target(target), .ccr_in(ccr_in),
    .mem_rdata(mem_rdata), .MR(mr), .MW(mw), .sel1(sel1), .sel2(sel2),
    .stall(stall), .pc_load(pc_load), .pc_out(pc_out),
    .ccr_load(ccr_load), .ccr_out(ccr_out)
  );

  assign ccr_in = ccr_cur;

  // Pipeline write-data mux driven by sel1.
  always_comb begin
    case (sel1)
      2'b10:   wdata = cur_pc[31:16];
      2'b01:   wdata = cur_pc[15:0];
      2'b11:   wdata = {CCR_PAD, ccr_cur};
      default: wdata = 16'hA1A1;
    endcase
  end

  assign mem_rdata = mem[sp + 11'd1];

  // Data-memory stack model owning the pointer.
  always @(posedge clk) begin
    if (rst) sp <= 11'd2047;
    else if (mw && sel2) begin
      mem[sp] <= wdata;
      sp      <= sp - 11'd1;
    end else if (mr && sel2) sp <= sp + 11'd1;
  end

  // ctl = {stall, MR, MW, sel1, sel2, pc_load, ccr_load}
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_REQ  = 8'b1000_0000;
  localparam logic [7:0] C_POP  = 8'b1100_0100;
  localparam logic [7:0] C_DONE = 8'b0000_0010;
  localparam logic [7:0] C_DRTI = 8'b0000_0011;

  function automatic logic [7:0] c_push(input logic [1:0] s);
    return {1'b1, 1'b0, 1'b1, s, 1'b1, 2'b00};
  endfunction

  // Compare outputs at the falling edge, then advance to just after the next rising edge.
  task automatic check_cycle(input string nm, input logic [7:0] ec,
                             input bit cd, input logic [31:0] ep, input logic [2:0] eo);
    logic [7:0] ac;
    bit         bad;
    @(negedge clk);
    ac  = {stall, mr, mw, sel1, sel2, pc_load, ccr_load};
    bad = (ac !== ec);
    if (cd && (pc_out !== ep || ccr_out !== eo)) bad = 1'b1;
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b pc=%h ccr=%b, expected ctl=%b pc=%h ccr=%b",
               nm, ac, pc_out, ccr_out, ec, ep, eo);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic i, input logic t);
    call_req = c; ret_req = r; int_req = i; rti_req = t;
  endtask

  task automatic noise();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    target = $urandom;
  endtask

  typedef struct {
    logic        rst, call, ret;
    logic [31:0] tgt;
    logic [7:0]  ec;
    bit          cd;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] w, lo, hi;
    logic [31:0] exp_pc;
    logic [2:0]  exp_ccr;
    int          op, gap;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,           C_IDLE,         1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,           C_IDLE,         1'b1, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0123,   C_REQ,          1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF,   c_push(2'b10),  1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0BAD_F00D,   c_push(2'b01),  1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,           C_DONE,         1'b1, 32'h0000_0123};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,           C_REQ,          1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,           C_POP,          1'b0, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,           C_POP,          1'b0, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,           C_DONE,         1'b1, 32'h0000_0123};

    rst = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0);
    target = 32'h0; cur_pc = 32'h0000_0123; ccr_cur = 3'b000;
    @(posedge clk); #1;

    // Directed CALL then RET from the table.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; call_req = tbl[i].call; ret_req = tbl[i].ret; target = tbl[i].tgt;
      check_cycle($sformatf("tbl[%0d]", i), tbl[i].ec, tbl[i].cd, tbl[i].ep, 3'b000);
      if (i == 5) begin
        check_val("call_word_2047", {16'h0, mem[2047]}, 32'h0000_0000);
        check_val("call_word_2046", {16'h0, mem[2046]}, 32'h0000_0123);
      end
    end
    check_val("sp_restored", {21'h0, sp}, 32'd2047);

    // Reset while in PUSH_LO.
    drive(1'b1, 1'b0, 1'b0, 1'b0); target = 32'h0000_0555;
    check_cycle("rst_req", C_REQ, 1'b0, 32'h0, 3'b000);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_cycle("rst_pushhi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
    rst = 1'b1;
    check_cycle("rst_pushlo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
    rst = 1'b0;
    check_cycle("rst_after", C_IDLE, 1'b1, 32'h0, 3'b000);
    check_cycle("rst_after2", C_IDLE, 1'b1, 32'h0, 3'b000);

    if (INT_EN) begin
      // INT push order, then RTI restore.
      cur_pc = 32'h0000_0040; ccr_cur = 3'b101;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_cycle("int_req", C_REQ, 1'b0, 32'h0, 3'b000);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_cycle("int_ccr", c_push(2'b11), 1'b0, 32'h0, 3'b000);
      check_cycle("int_hi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
      check_cycle("int_lo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
      check_cycle("int_done", C_DONE, 1'b1, VEC, 3'b000);
      check_val("int_w2047", {16'h0, mem[2047]}, {16'h0, CCR_PAD, 3'b101});
      check_val("int_w2046", {16'h0, mem[2046]}, 32'h0000_0000);
      check_val("int_w2045", {16'h0, mem[2045]}, 32'h0000_0040);
      cur_pc = VEC; ccr_cur = 3'b010;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_cycle("rti_req", C_REQ, 1'b0, 32'h0, 3'b000);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_cycle("rti_p0", C_POP, 1'b0, 32'h0, 3'b000);
      check_cycle("rti_p1", C_POP, 1'b0, 32'h0, 3'b000);
      check_cycle("rti_p2", C_POP, 1'b0, 32'h0, 3'b000);
      check_cycle("rti_done", C_DRTI, 1'b1, 32'h0000_0040, 3'b101);
      // int beats call; held call runs straight after DONE.
      drive(1'b1, 1'b0, 1'b1, 1'b0); target = 32'h0000_0777;
      check_cycle("pri_req", C_REQ, 1'b0, 32'h0, 3'b000);
      int_req = 1'b0;
      check_cycle("pri_ccr", c_push(2'b11), 1'b0, 32'h0, 3'b000);
      check_cycle("pri_hi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
      check_cycle("pri_lo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
      check_cycle("pri_done", C_DONE, 1'b1, VEC, 3'b000);
      check_cycle("b2b_req", C_REQ, 1'b0, 32'h0, 3'b000);
      drive(1'b0, 1'b0, 1'b0, 1'b0); target = 32'h0;
      check_cycle("b2b_hi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
      check_cycle("b2b_lo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
      check_cycle("b2b_done", C_DONE, 1'b1, 32'h0000_0777, 3'b000);
    end else begin
      // Interrupt requests have no effect in this build.
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) check_cycle("int_off", C_IDLE, 1'b1, 32'h0, 3'b000);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) check_cycle("rti_off", C_IDLE, 1'b1, 32'h0, 3'b000);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random operation stream against the word-stack model.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    mstk.delete();
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, INT_EN ? 1'b0 : 1'($urandom_range(0, 1)),
              INT_EN ? 1'b0 : 1'($urandom_range(0, 1)));
        check_cycle("rnd_gap", C_IDLE, 1'b0, 32'h0, 3'b000);
      end
      op = $urandom_range(0, INT_EN ? 3 : 1);
      if (op == 1 && mstk.size() < 2) op = 0;
      if (op == 3 && mstk.size() < 3) op = 2;
      if ((op == 0 || op == 2) && mstk.size() > 1500) op = 1;
      if (op == 0 || op == 2) begin
        cur_pc = $urandom; ccr_cur = 3'($urandom_range(0, 7));
      end
      target = $urandom;
      case (op)
        0: drive(1'b1, 1'($urandom_range(0, 1)),
                 INT_EN ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: drive(1'b0, 1'b1, INT_EN ? 1'b0 : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        2: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 1'($urandom_range(0, 1)));
        default: drive(1'b0, 1'b0, 1'b0, 1'b1);
      endcase
      exp_pc = target; exp_ccr = 3'b000;
      check_cycle("rnd_req", C_REQ, 1'b0, 32'h0, 3'b000);
      case (op)
        0: begin
          mstk.push_back(cur_pc[31:16]); mstk.push_back(cur_pc[15:0]);
          noise(); check_cycle("rnd_call_hi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_call_lo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_call_done", C_DONE, 1'b1, exp_pc, 3'b000);
        end
        1: begin
          lo = mstk.pop_back(); hi = mstk.pop_back(); exp_pc = {hi, lo};
          noise(); check_cycle("rnd_ret_p0", C_POP, 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_ret_p1", C_POP, 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_ret_done", C_DONE, 1'b1, exp_pc, 3'b000);
        end
        2: begin
          mstk.push_back({CCR_PAD, ccr_cur});
          mstk.push_back(cur_pc[31:16]); mstk.push_back(cur_pc[15:0]);
          noise(); check_cycle("rnd_int_ccr", c_push(2'b11), 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_int_hi", c_push(2'b10), 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_int_lo", c_push(2'b01), 1'b0, 32'h0, 3'b000);
          exp_pc = VEC;
          noise(); check_cycle("rnd_int_done", C_DONE, 1'b1, exp_pc, 3'b000);
        end
        default: begin
          lo = mstk.pop_back(); hi = mstk.pop_back(); w = mstk.pop_back();
          exp_pc = {hi, lo}; exp_ccr = w[2:0];
          noise(); check_cycle("rnd_rti_p0", C_POP, 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_rti_p1", C_POP, 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_rti_p2", C_POP, 1'b0, 32'h0, 3'b000);
          noise(); check_cycle("rnd_rti_done", C_DRTI, 1'b1, exp_pc, exp_ccr);
          ccr_cur = exp_ccr;
        end
      endcase
      cur_pc = exp_pc;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_cycle("final_idle", C_IDLE, 1'b1, 32'h0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
